multi_servo_pwm: RTL and testbench
==================================

// Module: multi_servo_pwm
// PURPOSE
//  Multi-channel servo PWM generator; next generation of the single-channel servo driver.
//  Drives NUM_CH servo outputs from one shared period timer with 1 us pulse resolution.
//  Per-channel pulse targets are written via a valid/ready port.
//  Active widths reload only at period boundaries, so no runt or extended pulses occur.
//  Optional per-period slew limit; sits between the control FSM and the servo pins.
// PARAMETERS
//  NUM_CH        4      number of servo channels (1..16)
//  SYS_FREQ_MHZ  25     clk frequency in MHz; prescaler divides to a 1 us tick
//  PERIOD_US     20000  PWM period in us
//  PULSE_MIN_US  1000   minimum pulse width in us; clamp floor
//  PULSE_MAX_US  2000   maximum pulse width in us; clamp ceiling (< PERIOD_US)
//  SLEW_US       0      max change of active width per period in us; 0 = no limit
//  PW_W          derived: $clog2(PERIOD_US+1); width of all us quantities
//  CH_W          derived: max(1,$clog2(NUM_CH))
// PORTS
//  clk           in   1         system clock
//  reset_n       in   1         asynchronous reset, active low
//  wr_valid      in   1         write request
//  wr_ready      out  1         write accepted when wr_valid && wr_ready
//  wr_ch         in   CH_W      target channel index
//  wr_pulse_us   in   PW_W      requested pulse width in us
//  wr_err        out  1         1-cycle pulse: accepted write had wr_ch >= NUM_CH
//  ch_enable     in   NUM_CH    per-channel enable; sampled at period start only
//  period_start  out  1         1-cycle pulse when the period counter wraps to 0
//  servo_out     out  NUM_CH    PWM outputs, registered
// BEHAVIOUR
//  - Reset (async, reset_n=0): prescaler=0; us_count=0; servo_out=0; period_start=0; wr_err=0.
//    Reset also sets wr_ready=0, en_q=0, and every target/active = CENTER.
//    CENTER = (PULSE_MIN_US+PULSE_MAX_US)/2, integer-truncated.
//  - wr_ready goes high on the first clk edge after reset release.
//  - Prescaler counts 0..SYS_FREQ_MHZ-1; us_tick is high when prescaler==SYS_FREQ_MHZ-1.
//  - us_count advances on us_tick and wraps from PERIOD_US-1 to 0.
//  - wrap_cyc = us_tick && us_count==PERIOD_US-1.
//  - Wrap edge (end of wrap_cyc): us_count<=0, period_start<=1, en_q<=ch_enable.
//    Also on this edge, for each ch, active<=step(active,target).
//  - step(): with d=target-active, if SLEW_US==0 or |d|<=SLEW_US, result is target.
//    Otherwise result is active +/- SLEW_US toward target.
//  - Write port: wr_ready=0 during wrap_cyc, 1 in all other cycles after reset.
//  - Accepted write with wr_ch<NUM_CH: target[wr_ch] <= clamp(wr_pulse_us, MIN, MAX).
//    The new target takes effect at the next wrap edge, never mid-period.
//  - Accepted write with wr_ch>=NUM_CH: all state unchanged; wr_err=1 on the next cycle.
//  - Repeated writes in one period: the last one wins.
//  - Output: servo_out[ch] <= en_q[ch] && (us_count < active[ch]); one clk latency.
//    High time = active[ch] us exactly.
//  - Enable changes mid-period are ignored until the next wrap edge; pulses are never truncated.
//  - All comparisons are unsigned at PW_W. Slew arithmetic uses PW_W+1 signed, with no overflow.
//  - Mid-operation reset: all outputs drop low immediately (async).
//    After release, restart at us_count=0 with channels disabled and CENTER widths.
// TESTING (bench params: SYS_FREQ_MHZ=2, PERIOD_US=100, MIN=10, MAX=20, SLEW_US=0)
//  1 Reset, ch_enable=4'hF, no writes.
//    -> after first period_start, each servo_out is high 15 us (30 clk) per 100 us period.
//  2 Write ch1=12 mid-period.
//    -> current period ch1 stays 15 us; next period ch1 is 12 us; other channels unaffected.
//  3 Write ch0=5, then ch2=50.
//    -> ch0 is 10 us and ch2 is 20 us (clamped); wr_err stays 0.
//  4 wr_valid held high across wrap_cyc.
//    -> wr_ready=0 for exactly 1 clk; write lands the next cycle; no write lost.
//  5 Rebuild with SLEW_US=3; ch3 from 15, write 20.
//    -> widths 18, 20 in consecutive periods; then write 10 -> 17, 14, 11, 10.
//  6 Write wr_ch=5 -> wr_err pulses 1 clk, targets unchanged.
//    Then drop ch_enable[0] mid-pulse -> ch0 pulse completes; next period low.
//    Then assert reset_n=0 mid-pulse -> servo_out=0 immediately.

Source files
------------

// File: rtl/multi_servo_pwm.sv
// Multi-channel servo PWM: one shared 1 us period timer drives NUM_CH lanes whose
// widths reload (optionally slew-limited) only at the period wrap.

module multi_servo_pwm_lane #(
    parameter int PW_W    = 15,
    parameter int CENTER  = 1500,
    parameter int SLEW_US = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [PW_W-1:0] wr_val,
    input  logic            wrap,
    input  logic            ch_en,
    input  logic [PW_W-1:0] us_count,
    output logic            servo_out
);
    localparam logic [PW_W-1:0] CENTER_L = PW_W'(CENTER);
    localparam logic [PW_W-1:0] SLEW_L   = PW_W'(SLEW_US);

    logic [PW_W-1:0]      target_q, target_d, active_q, active_d;
    logic                 en_q, en_d, out_q, out_d;
    logic signed [PW_W:0] diff;
    logic [PW_W:0]        mag;

    always_comb begin
        diff     = $signed({1'b0, target_q}) - $signed({1'b0, active_q});
        mag      = diff[PW_W] ? $unsigned(-diff) : $unsigned(diff);
        target_d = wr_en ? wr_val : target_q;
        en_d     = wrap ? ch_en : en_q;
        active_d = active_q;
        if (wrap) begin
            if (SLEW_US == 0 || mag <= {1'b0, SLEW_L}) active_d = target_q;
            else if (diff[PW_W])                       active_d = active_q - SLEW_L;
            else                                       active_d = active_q + SLEW_L;
        end
        out_d = en_q && (us_count < active_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q <= CENTER_L;
            active_q <= CENTER_L;
            en_q     <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            en_q     <= en_d;
            out_q    <= out_d;
        end
    end

    assign servo_out = out_q;
endmodule

module multi_servo_pwm #(
    parameter int NUM_CH       = 4,
    parameter int SYS_FREQ_MHZ = 25,
    parameter int PERIOD_US    = 20000,
    parameter int PULSE_MIN_US = 1000,
    parameter int PULSE_MAX_US = 2000,
    parameter int SLEW_US      = 0,
    parameter int PW_W         = $clog2(PERIOD_US + 1),
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [PW_W-1:0]   wr_pulse_us,
    output logic              wr_err,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic              period_start,
    output logic [NUM_CH-1:0] servo_out
);
    localparam int              PS_W     = (SYS_FREQ_MHZ > 1) ? $clog2(SYS_FREQ_MHZ) : 1;
    localparam logic [PS_W-1:0] PS_MAX   = PS_W'(SYS_FREQ_MHZ - 1);
    localparam logic [PW_W-1:0] US_MAX   = PW_W'(PERIOD_US - 1);
    localparam logic [PW_W-1:0] MIN_L    = PW_W'(PULSE_MIN_US);
    localparam logic [PW_W-1:0] MAX_L    = PW_W'(PULSE_MAX_US);
    localparam int              CENTER   = (PULSE_MIN_US + PULSE_MAX_US) / 2;
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [PW_W-1:0] pulse;
    } wr_req_t;

    wr_req_t           req;
    logic [PS_W-1:0]   prescaler_q, prescaler_d;
    logic [PW_W-1:0]   us_count_q, us_count_d;
    logic              rdy_q, rdy_d, period_start_q, period_start_d, wr_err_q, wr_err_d;
    logic              us_tick, wrap_cyc, wr_fire, ch_ok;
    logic [PW_W-1:0]   pulse_clamped;
    logic [NUM_CH-1:0] lane_wr;

    always_comb begin
        req            = {wr_ch, wr_pulse_us};
        us_tick        = (prescaler_q == PS_MAX);
        wrap_cyc       = us_tick && (us_count_q == US_MAX);
        // Writes are held off in the wrap cycle so a target never changes under the reload.
        wr_ready       = rdy_q && !wrap_cyc;
        wr_fire        = wr_valid && wr_ready;
        ch_ok          = {1'b0, req.ch} < NUM_CH_L;
        pulse_clamped  = (req.pulse < MIN_L) ? MIN_L : ((req.pulse > MAX_L) ? MAX_L : req.pulse);
        prescaler_d    = us_tick ? '0 : prescaler_q + 1'b1;
        us_count_d     = wrap_cyc ? '0 : (us_tick ? us_count_q + 1'b1 : us_count_q);
        rdy_d          = 1'b1;
        period_start_d = wrap_cyc;
        wr_err_d       = wr_fire && !ch_ok;
        for (int i = 0; i < NUM_CH; i++)
            lane_wr[i] = wr_fire && ch_ok && (req.ch == CH_W'(i));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q    <= '0;
            us_count_q     <= '0;
            rdy_q          <= 1'b0;
            period_start_q <= 1'b0;
            wr_err_q       <= 1'b0;
        end else begin
            prescaler_q    <= prescaler_d;
            us_count_q     <= us_count_d;
            rdy_q          <= rdy_d;
            period_start_q <= period_start_d;
            wr_err_q       <= wr_err_d;
        end
    end

    assign period_start = period_start_q;
    assign wr_err       = wr_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        multi_servo_pwm_lane #(
            .PW_W   (PW_W),
            .CENTER (CENTER),
            .SLEW_US(SLEW_US)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_en    (lane_wr[g]),
            .wr_val   (pulse_clamped),
            .wrap     (wrap_cyc),
            .ch_en    (ch_enable[g]),
            .us_count (us_count_q),
            .servo_out(servo_out[g])
        );
    end
endmodule

// File: tb/tb_multi_servo_pwm.sv
// Bench for multi_servo_pwm: measures per-period pulse widths against a width/target model.
// DUT a: 4 channels, no slew. DUT b: 5 channels (so wr_ch can be out of range), slew 3.

module tb_multi_servo_pwm;
    localparam int PER_CLK = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, wr_valid, sel;
    logic [2:0] wr_ch;
    logic [6:0] wr_pulse;
    logic [4:0] ch_enable;
    logic       rdy_a, err_a, ps_a, rdy_b, err_b, ps_b;
    logic [3:0] so_a;
    logic [4:0] so_b;
    logic       rdy, err, ps;
    logic [4:0] so;

    multi_servo_pwm #(.NUM_CH(4), .SYS_FREQ_MHZ(2), .PERIOD_US(100), .PULSE_MIN_US(10),
                      .PULSE_MAX_US(20), .SLEW_US(0)) u_a (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid && !sel), .wr_ready(rdy_a),
        .wr_ch(wr_ch[1:0]), .wr_pulse_us(wr_pulse), .wr_err(err_a),
        .ch_enable(ch_enable[3:0]), .period_start(ps_a), .servo_out(so_a));

    multi_servo_pwm #(.NUM_CH(5), .SYS_FREQ_MHZ(2), .PERIOD_US(100), .PULSE_MIN_US(10),
                      .PULSE_MAX_US(20), .SLEW_US(3)) u_b (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid && sel), .wr_ready(rdy_b),
        .wr_ch(wr_ch), .wr_pulse_us(wr_pulse), .wr_err(err_b),
        .ch_enable(ch_enable), .period_start(ps_b), .servo_out(so_b));

    assign rdy = sel ? rdy_b : rdy_a;
    assign err = sel ? err_b : err_a;
    assign ps  = sel ? ps_b  : ps_a;
    assign so  = sel ? so_b  : {1'b0, so_a};

    int vectors = 0, miscompares = 0;
    int tgt[5], act[5];
    bit en_m[5];
    int nch, slew, chk_err;
    bit hold_pend;
    int hold_ch, hold_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampv(int v);
        return (v < 10) ? 10 : ((v > 20) ? 20 : v);
    endfunction

    function automatic int stepv(int a, int t, int s);
        int d = t - a;
        if (s == 0 || (d <= s && d >= -s)) return t;
        return (d > 0) ? a + s : a - s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 5; c++) begin tgt[c] = 15; act[c] = 15; en_m[c] = 0; end
        chk_err = -1; hold_pend = 0;
    endtask

    task automatic adv();
        @(negedge clk);
        if (chk_err >= 0) begin
            chk("wr_err", 32'(err), chk_err);
            chk_err = (chk_err == 1) ? 0 : -1;
        end
    endtask

    task automatic accept(input int c, input int v);
        if (c < nch) tgt[c] = clampv(v);
        chk_err = (c >= nch) ? 1 : 0;
    endtask

    task automatic drive_wr(input int c, input int v);
        wr_valid = 1'b1; wr_ch = 3'(c); wr_pulse = 7'(v);
        chk("wr_ready", 32'(rdy), 1);
        accept(c, v);
    endtask

    task automatic wait_ps(output int hi);
        int k = 0;
        hi = 0;
        while (ps !== 1'b1 && k < 600) begin hi += (so != 0) ? 1 : 0; adv(); k++; end
        chk("period_start_seen", 32'(ps), 1);
    endtask

    // One full PWM period starting at the period_start cycle, with optional writes,
    // an enable change and a write held across the closing wrap cycle.
    task automatic window(input int w1_at, input int w1_ch, input int w1_val,
                          input int w2_at, input int w2_ch, input int w2_val,
                          input int en_at, input logic [4:0] en_val, input bit hold);
        int cnt[5];
        int bad, rlow, last_acc, hi;
        logic e;
        wait_ps(hi);
        for (int c = 0; c < nch; c++) begin
            act[c] = stepv(act[c], tgt[c], slew);
            en_m[c] = ch_enable[c];
            cnt[c] = 0;
        end
        bad = 0; rlow = 0; last_acc = -5;
        for (int i = 0; i < PER_CLK; i++) begin
            if (last_acc == i - 1) wr_valid = 1'b0;
            if (i == 0 && hold_pend) begin
                chk("wr_ready_after_wrap", 32'(rdy), 1);
                accept(hold_ch, hold_val);
                hold_pend = 0; last_acc = 0;
            end
            if (i == w1_at) begin drive_wr(w1_ch, w1_val); last_acc = i; end
            if (i == w2_at) begin drive_wr(w2_ch, w2_val); last_acc = i; end
            if (i == en_at) ch_enable = en_val;
            if (hold && i == PER_CLK - 1) begin
                wr_valid = 1'b1; wr_ch = 3'(hold_ch); wr_pulse = 7'(hold_val);
                chk("wr_ready_in_wrap", 32'(rdy), 0);
                hold_pend = 1;
            end
            rlow += (rdy === 1'b0) ? 1 : 0;
            for (int c = 0; c < nch; c++) begin
                e = en_m[c] && (i >= 1) && (i <= 2 * act[c]);
                cnt[c] += (so[c] === 1'b1) ? 1 : 0;
                bad += (so[c] !== e) ? 1 : 0;
            end
            adv();
        end
        for (int c = 0; c < nch; c++)
            chk($sformatf("width_ch%0d", c), cnt[c], en_m[c] ? 2 * act[c] : 0);
        chk("pulse_shape", bad, 0);
        chk("ready_low_cycles", rlow, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        sel = 0; nch = 4; slew = 0;
        wr_valid = 0; wr_ch = 0; wr_pulse = 0; ch_enable = 5'h0F; reset_n = 0;
        hold_ch = 0; hold_val = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_servo_out", 32'(so), 0);
        chk("rst_period_start", 32'(ps), 0);
        chk("rst_wr_ready", 32'(rdy), 0);
        chk("rst_wr_err", 32'(err), 0);
        reset_n = 1;
        adv();
        chk("ready_after_release", 32'(rdy), 1);
        wait_ps(hi);
        chk("first_period_idle", hi, 0);

        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);
        window(50, 1, 12, -1, 0, 0, -1, 5'h0, 0);     // ch1 still 15 here
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);      // ch1 now 12
        window(20, 0, 5, 60, 2, 50, -1, 5'h0, 0);     // clamps to 10 / 20
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);
        hold_ch = 3; hold_val = 18;
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 1);
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);      // ch3 now 18
        window(-1, 0, 0, -1, 0, 0, 10, 5'h0E, 0);     // ch0 dropped mid-pulse
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);

        repeat (10) adv();
        chk("pre_reset_ch1_high", 32'(so[1]), 1);
        reset_n = 0;
        #1;
        chk("midrst_servo_out", 32'(so), 0);
        chk("midrst_period_start", 32'(ps), 0);
        chk("midrst_wr_ready", 32'(rdy), 0);
        model_reset();
        ch_enable = 5'h1F;
        repeat (3) adv();
        reset_n = 1;
        adv();
        chk("ready_after_rerelease", 32'(rdy), 1);
        wait_ps(hi);
        chk("post_reset_idle", hi, 0);
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);

        sel = 1; nch = 5; slew = 3;
        window(30, 3, 20, -1, 0, 0, -1, 5'h0, 0);
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);      // ch3 18
        window(30, 3, 10, -1, 0, 0, -1, 5'h0, 0);     // ch3 20
        repeat (4) window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);
        window(30, 5, 17, 100, 7, 3, -1, 5'h0, 0);    // out-of-range writes
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);

        repeat (8)
            window(30, $urandom_range(0, 7), $urandom_range(0, 40),
                   120, $urandom_range(0, 7), $urandom_range(0, 40),
                   100, 5'($urandom), 0);
        window(-1, 0, 0, -1, 0, 0, -1, 5'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
